pulse_stretcher_multi: RTL and testbench
========================================

PULSE_STRETCHER_MULTI -- requirements
Module: pulse_stretcher_multi

Interface
REQ-001 Parameter par_channels, default 4, number of independent stretch channels (1..32).
REQ-002 Parameter par_T_stretch_val, default 64, cycles o_y is held high per trigger (0 = pass-through).
REQ-003 Parameter par_T_holdoff_val, default 0, low-time lockout cycles after each stretch ends (0 = none).
REQ-004 Parameter par_retrigger, default 0, 1 = trigger during hold restarts the hold timer.
REQ-005 Parameter par_edge_detect, default 0, 0 = level trigger, 1 = rising-edge trigger.
REQ-006 Parameter par_T_timer_bits, default $clog2(max(par_T_stretch_val, par_T_holdoff_val, 2)), timer width.
REQ-007 i_clk  input  1  clock; all state on rising edge.
REQ-008 i_rst  input  1  reset, synchronous, active-high.
REQ-009 i_x  input  par_channels  per-channel trigger inputs, synchronous to i_clk.
REQ-010 o_y  output  par_channels  per-channel stretched outputs.
REQ-011 o_missed  output  par_channels  one-cycle pulse per channel when a trigger is ignored.
REQ-012 o_active_any  output  1  OR-reduction of o_y.

Function
REQ-013 Each channel is a Moore FSM with states ST_IDLE, ST_HOLD, ST_GUARD; o_y[n] SHALL be 1 only in ST_HOLD, decoded from the state register only.
REQ-014 Trigger: level mode trig = i_x[n]; edge mode trig = i_x[n] & ~x_prev[n], x_prev a register cleared by reset.
REQ-015 ST_IDLE, trig in cycle k -> ST_HOLD from k+1; o_y[n] high exactly cycles k+1..k+T (T = par_T_stretch_val).
REQ-016 Timer zeroes on every state change and on retrigger, increments otherwise, saturates at its terminal value.
REQ-017 ST_HOLD exits when timer = T-1: to ST_GUARD if par_T_holdoff_val > 0, else ST_IDLE.
REQ-018 ST_GUARD lasts exactly par_T_holdoff_val cycles (o_y low), then ST_IDLE; trig ignored throughout.
REQ-019 par_retrigger = 1: trig in ST_HOLD at cycle m (including final hold cycle) resets timer; o_y stays high through m+T.
REQ-020 par_retrigger = 0: trig in ST_HOLD ignored.
REQ-021 o_missed[n] SHALL be registered, high in cycle j+1 for each ignored trig at cycle j (ST_GUARD, or ST_HOLD with par_retrigger = 0).
REQ-022 Channels fully independent; simultaneous triggers on all channels are each serviced with no cross-channel effect.
REQ-023 par_T_stretch_val = 1: o_y[n] = trig registered one cycle (holdoff/retrigger still apply).
REQ-024 par_T_stretch_val = 0: o_y = i_x combinationally, o_missed = 0, no state, holdoff/edge ignored.
REQ-025 o_active_any combinational OR of o_y, zero latency.

Reset
REQ-026 i_rst high: all channels ST_IDLE, timers 0, x_prev 0, o_y 0, o_missed 0, o_active_any 0, next cycle.
REQ-027 Reset mid-hold or mid-guard SHALL abort immediately; no residual pulse after release.
REQ-028 Level mode: i_x high at reset release triggers on the first cycle after release.

Structure
REQ-029 Package pulse_stretcher_pkg SHALL hold t_stretch_state enum and a max-of-three width helper function.
REQ-030 One sub-module, pulse_stretcher_chan (one channel FSM + timer + edge register), instantiated par_channels times via generate.
REQ-031 Top level SHALL contain only the generate loop, the OR reduction and the pass-through branch.

Verification
REQ-032 N=4,T=5,H=0,level: i_x[0] one-cycle pulse at k -> o_y[0] high k+1..k+5, other channels 0, o_missed 0.
REQ-033 T=5,H=3,retrig=0: pulses at k and k+2 and k+6 -> o_y high k+1..k+5, o_missed at k+3 and k+7, IDLE at k+9.
REQ-034 T=5,retrig=1: pulses at k,k+3,k+7 -> o_y continuously high k+1..k+12, o_missed never.
REQ-035 T=5,edge: i_x held high 20 cycles from k -> exactly one 5-cycle o_y pulse k+1..k+5.
REQ-036 T=5: all 4 channels triggered at k, i_rst at k+3 -> o_y all 0 at k+4 onward, o_active_any 0.
REQ-037 T=0 and T=1 builds: i_x pattern 1,0,1,1 -> o_y same pattern with 0 and 1 cycle latency respectively.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the multi-channel pulse stretcher.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pulse_stretcher_pkg;

  // Per-channel FSM state. The output is high only in ST_HOLD.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GUARD = 2'd2
  } t_stretch_state;

  // Largest of three values. Used to size the timer so that it can reach
  // both the hold and the holdoff terminal counts.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pulse_stretcher_chan.sv
// One stretch channel: trigger detect, IDLE/HOLD/GUARD Moore FSM and its timer.
// Latency: o_y rises one cycle after a trigger; o_missed is registered (one cycle).
// Backpressure: none; triggers that cannot be serviced are dropped and flagged.
//
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_x           trigger input (level or rising edge, by parameter)
//   o_y           stretched output, decoded from the state register
//   o_missed      one-cycle flag for a trigger ignored in HOLD (no retrigger) or GUARD
module pulse_stretcher_chan
  import pulse_stretcher_pkg::*;
#(
  parameter int par_T_stretch_val = 64,
  parameter int par_T_holdoff_val = 0,
  parameter int par_retrigger     = 0,
  parameter int par_edge_detect   = 0,
  parameter int par_T_timer_bits  = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_x,
  output logic o_y,
  output logic o_missed
);

  localparam logic [par_T_timer_bits-1:0] lp_hold_last  = par_T_timer_bits'(par_T_stretch_val - 1);
  localparam logic [par_T_timer_bits-1:0] lp_guard_last = par_T_timer_bits'(par_T_holdoff_val - 1);
  localparam bit lp_retrig = (par_retrigger != 0);
  localparam bit lp_edge   = (par_edge_detect != 0);
  localparam bit lp_guard  = (par_T_holdoff_val > 0);

  t_stretch_state              state_q, state_d;
  logic [par_T_timer_bits-1:0] timer_q, timer_d;
  logic                        x_prev_q;
  logic                        missed_q, missed_d;
  logic                        trig;

  assign trig = lp_edge ? (i_x & ~x_prev_q) : i_x;

  always_comb begin
    state_d  = state_q;
    missed_d = 1'b0;
    // Free-running timer that sticks at all-ones; every state change and
    // retrigger below overrides it with zero.
    timer_d  = (timer_q != '1) ? timer_q + 1'b1 : timer_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_HOLD;
          timer_d = '0;
        end
      end
      ST_HOLD: begin
        if (trig && lp_retrig) begin
          // Restart wins over expiry, so a trigger on the last hold cycle
          // still extends the pulse.
          timer_d = '0;
        end else begin
          missed_d = trig;
          if (timer_q == lp_hold_last) begin
            state_d = lp_guard ? ST_GUARD : ST_IDLE;
            timer_d = '0;
          end
        end
      end
      ST_GUARD: begin
        missed_d = trig;
        if (timer_q == lp_guard_last) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      x_prev_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      x_prev_q <= i_x;
      missed_q <= missed_d;
    end
  end

  assign o_y      = (state_q == ST_HOLD);
  assign o_missed = missed_q;

endmodule

// File: rtl/pulse_stretcher_multi.sv
// Bank of independent pulse stretchers, plus an any-active summary.
// Latency: 1 cycle trigger-to-output (0 in pass-through build); o_active_any is combinational.
// Backpressure: none; ignored triggers are reported on o_missed.
//
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_x           per-channel triggers
//   o_y           per-channel stretched outputs
//   o_missed      per-channel ignored-trigger pulses
//   o_active_any  OR of o_y
module pulse_stretcher_multi
  import pulse_stretcher_pkg::*;
#(
  parameter int par_channels      = 4,
  parameter int par_T_stretch_val = 64,
  parameter int par_T_holdoff_val = 0,
  parameter int par_retrigger     = 0,
  parameter int par_edge_detect   = 0,
  parameter int par_T_timer_bits  = $clog2(max3(par_T_stretch_val, par_T_holdoff_val, 2))
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [par_channels-1:0] i_x,
  output logic [par_channels-1:0] o_y,
  output logic [par_channels-1:0] o_missed,
  output logic                    o_active_any
);

  generate
    if (par_T_stretch_val == 0) begin : g_passthru
      // Zero-length stretch degenerates to a wire; no state at all.
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_rst;
      assign o_y            = i_x;
      assign o_missed       = '0;
    end else begin : g_stretch
      for (genvar g = 0; g < par_channels; g++) begin : g_chan
        pulse_stretcher_chan #(
          .par_T_stretch_val(par_T_stretch_val),
          .par_T_holdoff_val(par_T_holdoff_val),
          .par_retrigger    (par_retrigger),
          .par_edge_detect  (par_edge_detect),
          .par_T_timer_bits (par_T_timer_bits)
        ) u_chan (
          .i_clk   (i_clk),
          .i_rst   (i_rst),
          .i_x     (i_x[g]),
          .o_y     (o_y[g]),
          .o_missed(o_missed[g])
        );
      end
    end
  endgenerate

  assign o_active_any = |o_y;

endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Directed bench for pulse_stretcher_multi across several parameter builds.
// Latency: n/a.
// Backpressure: n/a.
module tb_pulse_stretcher_multi;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // a: T=5 H=0 level        b: T=5 H=3 no retrigger   c: T=5 retrigger
  // d: T=5 edge             e: T=0 pass-through       f: T=1 retrigger, 1 channel
  logic [3:0] x_a, y_a, m_a;  logic act_a;
  logic [3:0] x_b, y_b, m_b;  logic act_b;
  logic [3:0] x_c, y_c, m_c;  logic act_c;
  logic [3:0] x_d, y_d, m_d;  logic act_d;
  logic [3:0] x_e, y_e, m_e;  logic act_e;
  logic [0:0] x_f, y_f, m_f;  logic act_f;

  pulse_stretcher_multi #(.par_channels(4), .par_T_stretch_val(5), .par_T_holdoff_val(0),
                          .par_retrigger(0), .par_edge_detect(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_x(x_a), .o_y(y_a), .o_missed(m_a), .o_active_any(act_a));
  pulse_stretcher_multi #(.par_channels(4), .par_T_stretch_val(5), .par_T_holdoff_val(3),
                          .par_retrigger(0), .par_edge_detect(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_x(x_b), .o_y(y_b), .o_missed(m_b), .o_active_any(act_b));
  pulse_stretcher_multi #(.par_channels(4), .par_T_stretch_val(5), .par_T_holdoff_val(0),
                          .par_retrigger(1), .par_edge_detect(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_x(x_c), .o_y(y_c), .o_missed(m_c), .o_active_any(act_c));
  pulse_stretcher_multi #(.par_channels(4), .par_T_stretch_val(5), .par_T_holdoff_val(0),
                          .par_retrigger(0), .par_edge_detect(1)) dut_d (
    .i_clk(clk), .i_rst(rst), .i_x(x_d), .o_y(y_d), .o_missed(m_d), .o_active_any(act_d));
  pulse_stretcher_multi #(.par_channels(4), .par_T_stretch_val(0)) dut_e (
    .i_clk(clk), .i_rst(rst), .i_x(x_e), .o_y(y_e), .o_missed(m_e), .o_active_any(act_e));
  pulse_stretcher_multi #(.par_channels(1), .par_T_stretch_val(1), .par_T_holdoff_val(0),
                          .par_retrigger(1), .par_edge_detect(0)) dut_f (
    .i_clk(clk), .i_rst(rst), .i_x(x_f), .o_y(y_f), .o_missed(m_f), .o_active_any(act_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; everything afterwards happens 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    x_a = '0; x_b = '0; x_c = '0; x_d = '0; x_e = '0; x_f = '0;
    tick();
    tick();

    // Reset state on every build.
    check_eq("rst_y_a",   32'(y_a), 32'h0);
    check_eq("rst_m_a",   32'(m_a), 32'h0);
    check_eq("rst_act_a", 32'(act_a), 32'h0);
    check_eq("rst_y_b",   32'(y_b), 32'h0);
    check_eq("rst_y_f",   32'(y_f), 32'h0);
    rst = 1'b0;

    // Single pulse on channel 0, level mode: high for cycles 1..5 only.
    for (int c = 0; c <= 7; c++) begin
      x_a = (c == 0) ? 4'b0001 : 4'b0000;
      check_eq("a_pulse_y",   32'(y_a), (c >= 1 && c <= 5) ? 32'h1 : 32'h0);
      check_eq("a_pulse_act", 32'(act_a), (c >= 1 && c <= 5) ? 32'h1 : 32'h0);
      check_eq("a_pulse_m",   32'(m_a), 32'h0);
      tick();
    end

    // Level trigger held across reset release fires on the first free cycle.
    rst = 1'b1;
    x_a = 4'b0010;
    tick();
    rst = 1'b0;
    check_eq("a_rel_y0", 32'(y_a), 32'h0);
    tick();
    x_a = 4'b0000;
    check_eq("a_rel_y1", 32'(y_a), 32'h2);
    for (int c = 0; c < 6; c++) tick();
    check_eq("a_rel_done", 32'(y_a), 32'h0);

    // All channels at once, then reset mid-hold: no residual output.
    x_a = 4'hF;
    check_eq("a_all_k", 32'(y_a), 32'h0);
    tick();
    x_a = 4'h0;
    check_eq("a_all_k1", 32'(y_a), 32'hF);
    tick();
    tick();
    check_eq("a_all_k3",     32'(y_a), 32'hF);
    check_eq("a_all_k3_act", 32'(act_a), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("a_rst_y",   32'(y_a), 32'h0);
    check_eq("a_rst_act", 32'(act_a), 32'h0);
    check_eq("a_rst_m",   32'(m_a), 32'h0);
    for (int c = 5; c <= 9; c++) begin
      tick();
      check_eq("a_post_rst_y", 32'(y_a), 32'h0);
    end

    // Holdoff, no retrigger: pulses at 0,2,6 plus 9 to probe the return to IDLE.
    for (int c = 0; c <= 11; c++) begin
      x_b = (c == 0 || c == 2 || c == 6 || c == 9) ? 4'b0001 : 4'b0000;
      check_eq("b_y", 32'(y_b), ((c >= 1 && c <= 5) || c >= 10) ? 32'h1 : 32'h0);
      check_eq("b_m", 32'(m_b), (c == 3 || c == 7) ? 32'h1 : 32'h0);
      tick();
    end
    x_b = 4'b0000;

    // Retrigger: pulses at 0,3,7 keep the output high through cycle 12.
    for (int c = 0; c <= 14; c++) begin
      x_c = (c == 0 || c == 3 || c == 7) ? 4'b0001 : 4'b0000;
      check_eq("c_y", 32'(y_c), (c >= 1 && c <= 12) ? 32'h1 : 32'h0);
      check_eq("c_m", 32'(m_c), 32'h0);
      tick();
    end

    // Edge mode: a 20-cycle level yields exactly one 5-cycle pulse.
    for (int c = 0; c <= 22; c++) begin
      x_d = (c < 20) ? 4'b0001 : 4'b0000;
      check_eq("d_y", 32'(y_d), (c >= 1 && c <= 5) ? 32'h1 : 32'h0);
      check_eq("d_m", 32'(m_d), 32'h0);
      tick();
    end

    // T=0 pass-through (zero latency) and T=1 (one cycle latency), pattern 1,0,1,1.
    pat = 4'b1101;  // pat[c] for c = 0..3 is 1,0,1,1
    for (int c = 0; c <= 5; c++) begin
      x_e = (c <= 3) ? {3'b000, pat[c]} : 4'b0000;
      x_f = (c <= 3) ? pat[c] : 1'b0;
      #1;
      check_eq("e_y",   32'(y_e), 32'(x_e));
      check_eq("e_act", 32'(act_e), 32'(x_e[0]));
      check_eq("e_m",   32'(m_e), 32'h0);
      check_eq("f_y",   32'(y_f), (c >= 1 && c <= 4) ? 32'(pat[c-1]) : 32'h0);
      check_eq("f_m",   32'(m_f), 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
